// File: rtl/fp32_pair_feeder.sv
// Operand sequencer for the pipelined fp32 adder: buffers a framed word stream and issues word pairs.
// Optional FEEDER_DENORM_FLUSH_EN flushes popped denormals to signed zero.
module fp32_pair_feeder #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                     s_clk,
  input  logic                     s_rst,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [31:0]              i_data,
  input  logic                     i_last,
  input  logic                     i_stall,
  output logic                     o_data_valid,
  output logic [31:0]              o_data1,
  output logic [31:0]              o_data2,
  output logic                     o_pair_last,
  output logic [CNT_W-1:0]         o_frame_pairs,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]      LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]      LVL_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [0:0]       S_EMPTY  = 1'b0;
  localparam logic [0:0]       S_HOLD   = 1'b1;

  logic [32:0]      mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push;
  logic             pop;
  logic [32:0]      head;
  logic [31:0]      pop_word;
  logic             pop_last;
  logic [0:0]       state;
  logic [0:0]       next_state;
  logic [31:0]      hold;
  logic             load_hold;
  logic             issue;
  logic [31:0]      iss_d1;
  logic [31:0]      iss_d2;
  logic             iss_last;
  logic [CNT_W-1:0] pair_cnt;
  logic [CNT_W-1:0] cnt_inc;

  function automatic logic [31:0] flush_denorm(input logic [31:0] w);
`ifdef FEEDER_DENORM_FLUSH_EN
    if (w[30:23] == 8'h00) begin
      flush_denorm = {w[31], 31'h0};
    end else begin
      flush_denorm = w;
    end
`else
    flush_denorm = w;
`endif
  endfunction

  // FIFO handshake, head decode and pairing decisions
  always_comb begin
    o_ready    = ~s_rst & (o_level != LVL_FULL);
    push       = i_valid & o_ready;
    pop        = (o_level != '0) & ~i_stall;
    head       = mem[rd_ptr];
    pop_word   = flush_denorm(head[31:0]);
    pop_last   = head[32];
    cnt_inc    = (pair_cnt == CNT_MAX) ? pair_cnt : pair_cnt + CNT_ONE;
    next_state = state;
    load_hold  = 1'b0;
    issue      = 1'b0;
    iss_d1     = hold;
    iss_d2     = pop_word;
    iss_last   = pop_last;
    case (state)
      S_EMPTY: begin
        if (pop && pop_last) begin
          // lone trailing word is padded with +0.0
          issue  = 1'b1;
          iss_d1 = pop_word;
          iss_d2 = 32'h0000_0000;
        end else if (pop) begin
          load_hold  = 1'b1;
          next_state = S_HOLD;
        end else begin
          next_state = S_EMPTY;
        end
      end
      S_HOLD: begin
        if (pop) begin
          issue      = 1'b1;
          next_state = S_EMPTY;
        end else begin
          next_state = S_HOLD;
        end
      end
      default: begin
        next_state = S_EMPTY;
      end
    endcase
  end

  // FIFO storage, written only on accepted words
  always_ff @(posedge s_clk) begin
    if (push) begin
      mem[wr_ptr] <= {i_last, i_data};
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge s_clk or posedge s_rst) begin
    if (s_rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      o_level <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   o_level <= o_level + LVL_ONE;
        2'b01:   o_level <= o_level - LVL_ONE;
        default: o_level <= o_level;
      endcase
    end
  end

  // pairing state, issue registers and per-frame pair counter
  always_ff @(posedge s_clk or posedge s_rst) begin
    if (s_rst) begin
      state         <= S_EMPTY;
      hold          <= 32'h0000_0000;
      o_data_valid  <= 1'b0;
      o_data1       <= 32'h0000_0000;
      o_data2       <= 32'h0000_0000;
      o_pair_last   <= 1'b0;
      o_frame_pairs <= '0;
      pair_cnt      <= '0;
    end else begin
      state        <= next_state;
      o_data_valid <= issue;
      if (load_hold) begin
        hold <= pop_word;
      end
      if (issue) begin
        o_data1     <= iss_d1;
        o_data2     <= iss_d2;
        o_pair_last <= iss_last;
        if (iss_last) begin
          o_frame_pairs <= cnt_inc;
          pair_cnt      <= '0;
        end else begin
          pair_cnt <= cnt_inc;
        end
      end
    end
  end

endmodule

// File: tb/tb_fp32_pair_feeder.sv
// Directed bench for fp32_pair_feeder: framing, padding, stall/backpressure, reset and pass-through.
module tb_fp32_pair_feeder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [31:0] i_data = 32'h0;
  logic        i_last = 1'b0;
  logic        i_stall = 1'b0;
  logic        o_data_valid;
  logic [31:0] o_data1;
  logic [31:0] o_data2;
  logic        o_pair_last;
  logic [15:0] o_frame_pairs;
  logic [3:0]  o_level;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [64:0] pairs[$];
  int stamps[$];

  fp32_pair_feeder #(.DEPTH(8), .CNT_W(16)) dut (
    .s_clk(clk), .s_rst(rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_data(i_data), .i_last(i_last), .i_stall(i_stall),
    .o_data_valid(o_data_valid), .o_data1(o_data1), .o_data2(o_data2),
    .o_pair_last(o_pair_last), .o_frame_pairs(o_frame_pairs), .o_level(o_level)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // record every issued pair with the cycle it appeared in
  always @(negedge clk) begin
    if (o_data_valid) begin
      pairs.push_back({o_pair_last, o_data1, o_data2});
      stamps.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [64:0] got, input logic [64:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic expect_pair(input string tag, input logic [64:0] exp);
    logic [64:0] got;
    chk({tag, "_avail"}, 65'(pairs.size() != 0), 65'd1);
    if (pairs.size() != 0) begin
      got = pairs.pop_front();
      void'(stamps.pop_front());
      chk(tag, got, exp);
    end
  endtask

  task automatic send_word(input logic [31:0] w, input logic last);
    int n;
    @(negedge clk);
    i_valid = 1'b1;
    i_data  = w;
    i_last  = last;
    n = 0;
    while (!o_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("ready_timeout", 65'd0, 65'd1);
  endtask

  task automatic idle();
    @(negedge clk);
    i_valid = 1'b0;
    i_last  = 1'b0;
  endtask

  task automatic flush_q();
    pairs.delete();
    stamps.delete();
  endtask

  initial begin
    int s0;
    // reset state
    repeat (2) @(negedge clk);
    chk("rst_ready", 65'(o_ready), 65'd0);
    chk("rst_level", 65'(o_level), 65'd0);
    chk("rst_out", {o_data_valid, o_pair_last, o_data1, o_data2}, 65'd0);
    chk("rst_fp", 65'(o_frame_pairs), 65'd0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 65'(o_ready), 65'd1);

    // 1: even frame
    send_word(32'h3F800000, 1'b0);
    send_word(32'h40000000, 1'b0);
    send_word(32'h40400000, 1'b0);
    send_word(32'h40800000, 1'b1);
    idle();
    repeat (6) @(negedge clk);
    expect_pair("t1_p0", {1'b0, 32'h3F800000, 32'h40000000});
    expect_pair("t1_p1", {1'b1, 32'h40400000, 32'h40800000});
    chk("t1_extra", 65'(pairs.size()), 65'd0);
    chk("t1_fp", 65'(o_frame_pairs), 65'd2);
    chk("t1_level", 65'(o_level), 65'd0);

    // 2: odd frame, pad with +0.0
    send_word(32'h3F800000, 1'b0);
    send_word(32'h40000000, 1'b0);
    send_word(32'h40400000, 1'b1);
    idle();
    repeat (6) @(negedge clk);
    expect_pair("t2_p0", {1'b0, 32'h3F800000, 32'h40000000});
    expect_pair("t2_p1", {1'b1, 32'h40400000, 32'h00000000});
    chk("t2_extra", 65'(pairs.size()), 65'd0);
    chk("t2_fp", 65'(o_frame_pairs), 65'd2);

    // 3: single word, latency
    send_word(32'hC0A00000, 1'b1);
    idle();
    chk("t3_early", 65'(o_data_valid), 65'd0);
    @(negedge clk);
    chk("t3_valid", 65'(o_data_valid), 65'd1);
    chk("t3_pair", {o_pair_last, o_data1, o_data2}, {1'b1, 32'hC0A00000, 32'h00000000});
    chk("t3_fp", 65'(o_frame_pairs), 65'd1);
    @(negedge clk);
    chk("t3_pulse", 65'(o_data_valid), 65'd0);
    flush_q();

    // 4: stall fills FIFO, release drains on alternate cycles
    i_stall = 1'b1;
    for (int i = 0; i < 8; i++) send_word(32'h41000000 + 32'(i), (i == 7) ? 1'b1 : 1'b0);
    idle();
    chk("t4_level", 65'(o_level), 65'd8);
    chk("t4_ready", 65'(o_ready), 65'd0);
    chk("t4_nopair", 65'(pairs.size()), 65'd0);
    i_stall = 1'b0;
    @(negedge clk);
    chk("t4_ready_back", 65'(o_ready), 65'd1);
    chk("t4_level7", 65'(o_level), 65'd7);
    repeat (10) @(negedge clk);
    chk("t4_npairs", 65'(pairs.size()), 65'd4);
    if (stamps.size() == 4) begin
      s0 = stamps[0];
      for (int i = 1; i < 4; i++) chk("t4_spacing", 65'(stamps[i] - stamps[i-1]), 65'd2);
      chk("t4_first", 65'(s0 >= 0), 65'd1);
    end
    for (int i = 0; i < 4; i++)
      expect_pair("t4_p", {(i == 3) ? 1'b1 : 1'b0, 32'h41000000 + 32'(2*i), 32'h41000000 + 32'(2*i+1)});
    chk("t4_fp", 65'(o_frame_pairs), 65'd4);

    // 5: reset mid-frame
    send_word(32'h11111111, 1'b0);
    idle();
    @(negedge clk);
    i_stall = 1'b1;
    send_word(32'h22222222, 1'b0);
    send_word(32'h33333333, 1'b0);
    idle();
    chk("t5_level_pre", 65'(o_level), 65'd2);
    rst = 1'b1;
    #1;
    chk("t5_level", 65'(o_level), 65'd0);
    chk("t5_out", {o_data_valid, o_pair_last, o_data1, o_data2}, 65'd0);
    chk("t5_fp", 65'(o_frame_pairs), 65'd0);
    @(negedge clk);
    rst = 1'b0;
    i_stall = 1'b0;
    chk("t5_nopair", 65'(pairs.size()), 65'd0);
    send_word(32'hAAAA0000, 1'b0);
    send_word(32'hBBBB0000, 1'b1);
    idle();
    repeat (5) @(negedge clk);
    expect_pair("t5_p", {1'b1, 32'hAAAA0000, 32'hBBBB0000});
    chk("t5_extra", 65'(pairs.size()), 65'd0);
    chk("t5_fp1", 65'(o_frame_pairs), 65'd1);

    // 6: denormal handling and special-value pass-through
    send_word(32'h80000001, 1'b0);
    send_word(32'h3F800000, 1'b1);
    send_word(32'h7FC00001, 1'b0);
    send_word(32'hFF800000, 1'b1);
    idle();
    repeat (6) @(negedge clk);
`ifdef FEEDER_DENORM_FLUSH_EN
    expect_pair("t6_denorm", {1'b1, 32'h80000000, 32'h3F800000});
`else
    expect_pair("t6_denorm", {1'b1, 32'h80000001, 32'h3F800000});
`endif
    expect_pair("t6_special", {1'b1, 32'h7FC00001, 32'hFF800000});
    chk("t6_fp", 65'(o_frame_pairs), 65'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
